// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Accepted operations are latched, run through the ALU for one cycle, and the
// captured result/flags are returned on a single response channel tagged with
// the requester id.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req0_* / req1_*               per-requester valid/ready request with a, b, ctrl
//   alu_a, alu_b, alu_ctrl        registered operands/opcode to the shared ALU
//   alu_result, alu_flags         combinational ALU outputs
//   rsp_valid/rsp_ready           response handshake
//   rsp_id, rsp_result, rsp_flags captured response payload
//   busy                          high whenever the FSM is not IDLE
module alu_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_ctrl,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_ctrl,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         ptr_q, ptr_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [3:0]   ctrl_q, ctrl_d;
    logic         id_q, id_d;
    logic [N-1:0] res_q, res_d;
    logic [3:0]   flg_q, flg_d;
    logic         rsp_id_q, rsp_id_d;

    logic gnt_vld;
    logic gnt_id;

    // Grant: a lone requester wins outright; on contention the pointer decides.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_vld) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM-derived outputs; ready is only ever offered to the granted side in IDLE.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        if (state_q == IDLE) begin
            req0_ready = gnt_vld & ~gnt_id;
            req1_ready = gnt_vld &  gnt_id;
        end
        if (state_q == RESP) begin
            rsp_valid = 1'b1;
        end
        if (state_q != IDLE) begin
            busy = 1'b1;
        end
    end

    // Datapath next values: latch on grant, capture ALU outputs at end of EXEC.
    always_comb begin
        ptr_d    = ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        id_d     = id_q;
        res_d    = res_q;
        flg_d    = flg_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    a_d    = gnt_id ? req1_a    : req0_a;
                    b_d    = gnt_id ? req1_b    : req0_b;
                    ctrl_d = gnt_id ? req1_ctrl : req0_ctrl;
                    id_d   = gnt_id;
                end
            end
            EXEC: begin
                res_d    = alu_result;
                flg_d    = alu_flags;
                rsp_id_d = id_q;
            end
            RESP: begin
                // The side just served loses priority for the next contention.
                if (rsp_ready) ptr_d = ~rsp_id_q;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            id_q     <= 1'b0;
            res_q    <= '0;
            flg_q    <= '0;
            rsp_id_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            id_q     <= id_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = res_q;
    assign rsp_flags  = flg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single-requester operations
// plus hand-written sequences for contention, back-pressure and mid-op reset.
// A small ALU stub stands in for the shared datapath.
module tb_alu_arbiter;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst;
    logic         req0_valid, req0_ready;
    logic [N-1:0] req0_a, req0_b;
    logic [3:0]   req0_ctrl;
    logic         req1_valid, req1_ready;
    logic [N-1:0] req1_a, req1_b;
    logic [3:0]   req1_ctrl;
    logic [N-1:0] alu_a, alu_b;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         busy;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    // ALU stub: add/sub/xor results; flags chosen per operand pair so that
    // pass-through of arbitrary flag patterns is visible.
    function automatic logic [3:0] stub_flags(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'b0001 && b == 4'b0001) return 4'b0000;
        if (a == 4'b1111 && b == 4'b0001) return 4'b0100;
        if (a == 4'b1111 && b == 4'b1110) return 4'b1000;
        if (a == 4'b0111 && b == 4'b0100) return 4'b0011;
        return a ^ b;
    endfunction

    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_flags = stub_flags(alu_a, alu_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       sel;      // requester issuing the op
        logic [3:0] a, b, c;
        logic [3:0] eres, efl;
    } vec_t;

    vec_t vecs[4];

    // One isolated operation from IDLE with rsp_ready high; starts/ends at posedge+1.
    task automatic run_vec(input vec_t v, input int k);
        if (v.sel) begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_ctrl = v.c;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_ctrl = v.c;
        end
        #1;
        chk($sformatf("v%0d_ready0", k), 32'(req0_ready), 32'(!v.sel));
        chk($sformatf("v%0d_ready1", k), 32'(req1_ready), 32'(v.sel));
        step();
        idle_inputs();
        #1;
        chk($sformatf("v%0d_exec_busy", k), 32'(busy), 1);
        chk($sformatf("v%0d_exec_nvalid", k), 32'(rsp_valid), 0);
        chk($sformatf("v%0d_alu_a", k), 32'(alu_a), 32'(v.a));
        chk($sformatf("v%0d_alu_ctrl", k), 32'(alu_ctrl), 32'(v.c));
        step();
        chk($sformatf("v%0d_rsp_valid", k), 32'(rsp_valid), 1);
        chk($sformatf("v%0d_rsp_id", k), 32'(rsp_id), 32'(v.sel));
        chk($sformatf("v%0d_rsp_result", k), 32'(rsp_result), 32'(v.eres));
        chk($sformatf("v%0d_rsp_flags", k), 32'(rsp_flags), 32'(v.efl));
        step();
        chk($sformatf("v%0d_idle", k), 32'(busy), 0);
    endtask

    initial begin
        int  n;
        int  dual;
        int  cyc_at[4];
        logic ids[4];

        vecs[0] = '{sel: 1'b0, a: 4'b0001, b: 4'b0001, c: 4'b0000, eres: 4'b0010, efl: 4'b0000};
        vecs[1] = '{sel: 1'b0, a: 4'b0101, b: 4'b0011, c: 4'b0001, eres: 4'b0010, efl: 4'b0110};
        vecs[2] = '{sel: 1'b1, a: 4'b0111, b: 4'b0100, c: 4'b0000, eres: 4'b1011, efl: 4'b0011};
        vecs[3] = '{sel: 1'b1, a: 4'b1100, b: 4'b1010, c: 4'b0010, eres: 4'b0110, efl: 4'b0110};

        idle_inputs();
        rsp_ready = 1'b1;
        rst = 1'b1;
        #2;
        chk("reset_ready0", 32'(req0_ready), 0);
        chk("reset_ready1", 32'(req1_ready), 0);
        chk("reset_alu_a", 32'(alu_a), 0);
        chk("reset_rsp_result", 32'(rsp_result), 0);
        chk("reset_rsp_flags", 32'(rsp_flags), 0);
        do_reset();

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Last op came from requester 1, so contention must favour requester 0.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("ptr_fav0_ready0", 32'(req0_ready), 1);
        chk("ptr_fav0_ready1", 32'(req1_ready), 0);
        idle_inputs();
        #1;

        // Contention straight after reset: 0 first, then 1.
        do_reset();
        req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'b0001;
        req1_valid = 1'b1; req1_a = 4'b1111; req1_b = 4'b0001;
        #1;
        chk("t2_ready0", 32'(req0_ready), 1);
        chk("t2_ready1", 32'(req1_ready), 0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("t2_exec_ready1", 32'(req1_ready), 0);
        step();
        chk("t2_rsp0_id", 32'(rsp_id), 0);
        chk("t2_rsp0_result", 32'(rsp_result), 32'(4'b0010));
        chk("t2_resp_ready1", 32'(req1_ready), 0);
        step();
        chk("t2_idle_ready1", 32'(req1_ready), 1);
        step();
        req1_valid = 1'b0;
        step();
        chk("t2_rsp1_valid", 32'(rsp_valid), 1);
        chk("t2_rsp1_id", 32'(rsp_id), 1);
        chk("t2_rsp1_result", 32'(rsp_result), 32'(4'b0000));
        chk("t2_rsp1_flags", 32'(rsp_flags), 32'(4'b0100));
        step();

        // Both continuously valid: alternating grants, one response per 3 cycles.
        req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'b0001; req0_ctrl = 4'b0000;
        req1_valid = 1'b1; req1_a = 4'b0001; req1_b = 4'b0001; req1_ctrl = 4'b0000;
        n = 0; dual = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) dual++;
            if (rsp_valid && rsp_ready) begin
                ids[n] = rsp_id;
                cyc_at[n] = c;
                n++;
            end
            step();
        end
        idle_inputs();
        chk("t3_resp_count", 32'(n), 4);
        chk("t3_no_dual_ready", 32'(dual), 0);
        if (n == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t3_id%0d", i), 32'(ids[i]), 32'(i % 2));
                if (i > 0) chk($sformatf("t3_gap%0d", i), 32'(cyc_at[i] - cyc_at[i-1]), 3);
            end
        end
        #1;
        chk("t3_idle", 32'(busy), 0);

        // Back-pressure: response held for 5 cycles, no grants meanwhile.
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 4'b1111; req1_b = 4'b1110; req1_ctrl = 4'b0000;
        #1;
        chk("t4_ready1", 32'(req1_ready), 1);
        step();
        idle_inputs();
        req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'b0001;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_hold%0d_valid", i), 32'(rsp_valid), 1);
            chk($sformatf("t4_hold%0d_result", i), 32'(rsp_result), 32'(4'b1101));
            chk($sformatf("t4_hold%0d_flags", i), 32'(rsp_flags), 32'(4'b1000));
            chk($sformatf("t4_hold%0d_ready0", i), 32'(req0_ready), 0);
            chk($sformatf("t4_hold%0d_ready1", i), 32'(req1_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t4_release_valid", 32'(rsp_valid), 1);
        step();
        chk("t4_next_grant0", 32'(req0_ready), 1);
        step();
        req0_valid = 1'b0;
        step();
        chk("t4_rsp2_id", 32'(rsp_id), 0);
        chk("t4_rsp2_result", 32'(rsp_result), 32'(4'b0010));
        step();
        chk("t4_idle", 32'(busy), 0);

        // Asynchronous reset in the middle of EXEC.
        req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'b0001; req0_ctrl = 4'b0000;
        step();
        idle_inputs();
        #1;
        chk("t5_exec_busy", 32'(busy), 1);
        chk("t5_exec_alu_a", 32'(alu_a), 32'(4'b0011));
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_valid", 32'(rsp_valid), 0);
        chk("t5_rst_alu_a", 32'(alu_a), 0);
        chk("t5_rst_alu_b", 32'(alu_b), 0);
        #1;
        rst = 1'b0;
        step();
        chk("t5_post_busy", 32'(busy), 0);
        step();
        chk("t5_no_rsp", 32'(rsp_valid), 0);
        req0_valid = 1'b1; req0_a = 4'b0010; req0_b = 4'b0011; req0_ctrl = 4'b0000;
        req1_valid = 1'b1; req1_a = 4'b0101; req1_b = 4'b0001; req1_ctrl = 4'b0000;
        #1;
        chk("t5_ptr0_ready0", 32'(req0_ready), 1);
        chk("t5_ptr0_ready1", 32'(req1_ready), 0);
        step();
        idle_inputs();
        step();
        chk("t5_rsp_valid", 32'(rsp_valid), 1);
        chk("t5_rsp_id", 32'(rsp_id), 0);
        chk("t5_rsp_result", 32'(rsp_result), 32'(4'b0101));
        chk("t5_rsp_flags", 32'(rsp_flags), 32'(4'b0001));
        step();
        chk("t5_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance (operands a/b, 4-bit ctrl, N-bit result, 4-bit flags) between two requesters.
- Uses round-robin arbitration with a valid/ready request handshake per requester.
- Sequences each granted operation through the ALU and captures the result and flags into registers.
- Returns the captured values on one shared response channel, tagged with the requester id.
- Sits between the decode/issue logic of two pipelines or units and the shared ALU datapath.

Parameters:
N, 4, operand/result width; must match the N of the attached ALU.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  N  requester 0 operand a
req0_b  input  N  requester 0 operand b
req0_ctrl  input  4  requester 0 ALU opcode (0000 = add, 0001 = sub, ...)
req1_valid  input  1  requester 1 has an operation pending
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  N  requester 1 operand a
req1_b  input  N  requester 1 operand b
req1_ctrl  input  4  requester 1 ALU opcode
alu_a  output  N  operand a to shared ALU
alu_b  output  N  operand b to shared ALU
alu_ctrl  output  4  opcode to shared ALU
alu_result  input  N  ALU result
alu_flags  input  4  ALU flags: 3 = negative, 2 = zero, 1 = carry, 0 = overflow
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_id  output  1  requester id of the response
rsp_result  output  N  captured result
rsp_flags  output  4  captured flags, bit order unchanged
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst=1):
  - State = IDLE, priority pointer ptr = 0.
  - Operand, opcode, id, result and flag registers = 0.
  - All outputs 0: req*_ready, rsp_valid, busy, alu_a/b/ctrl, rsp_*.
  - An operation in flight is discarded and no response is produced.
- alu_a, alu_b and alu_ctrl are driven only from the internal operand registers, never combinationally from req*.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from the valids. Only req0_valid → grant 0. Only req1_valid → grant 1. Both → grant ptr. Neither → stay IDLE.
  - reqX_ready = 1 only for the granted requester, only in IDLE. At most one ready is high per cycle.
  - On the grant edge, latch that requester's a, b, ctrl and id, then go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable from the registers.
  - At the end of the cycle, capture alu_result → rsp_result, alu_flags → rsp_flags, id → rsp_id, then go to RESP.
- RESP:
  - rsp_valid = 1. rsp_id, rsp_result and rsp_flags are held stable until the handshake.
  - rsp_valid & rsp_ready → ptr = ~rsp_id, go to IDLE.
  - rsp_ready low → stay in RESP indefinitely. No req*_ready is asserted.
- Latency: request accepted in cycle t → rsp_valid first high in cycle t+2.
- Throughput: with rsp_ready tied high, one operation per 3 cycles (accept, exec, respond).
- Requesters must hold valid and payload stable until ready. The block does not check this. A valid dropped before grant is simply not served.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- The ALU result is not modified: width N, wrap-around is the ALU's behaviour, and flags pass through unchanged.
- rst asserted in any state returns to the reset values on the same edge (asynchronous). Operation resumes from IDLE on the first clock after deassertion.

Test Plan:
1. Reset, then req0 {a=0001, b=0001, ctrl=0000} → req0_ready=1 in the same cycle; rsp_valid=1 two cycles later with rsp_id=0, rsp_result=0010, rsp_flags=0000.
2. req0 {0001+0001} and req1 {1111+0001, ctrl=0000} both valid right after reset → req0 granted first while req1_ready stays 0; after the response handshake req1 is granted; second response has rsp_id=1, result=0000, flags=0100.
3. Both requesters held valid for 4 operations with rsp_ready=1 → rsp_id sequence 0,1,0,1, one response every 3 cycles, req0_ready and req1_ready never high together.
4. rsp_ready held 0 for 5 cycles with req1 {1111+1110} pending → rsp_valid stays 1, result=1101, flags=1000 stable; no req*_ready; after rsp_ready=1 the next grant follows.
5. rst pulsed mid-EXEC (asynchronous, between clock edges) → rsp_valid, busy and alu_* go 0 immediately, ptr=0; no response for the aborted operation; next request is serviced normally.
6. req1 alone {0111+0100, ctrl=0000} → rsp_result=1011, rsp_flags=0011 passed through unchanged; ptr then favours requester 0.
